// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding, FSM
// state type and opcode-class predicates reused by the CPU hazard logic.
package md_unit_pkg;

  localparam int MD_OP_LEN = 4;

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MADD  = 4'd5,
    MD_OP_MADDU = 4'd6,
    MD_OP_MSUB  = 4'd7,
    MD_OP_MSUBU = 4'd8,
    MD_OP_MTHI  = 4'd9,
    MD_OP_MTLO  = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic is_mul_op(input logic [MD_OP_LEN-1:0] op);
    return op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MADDU,
                      MD_OP_MSUB, MD_OP_MSUBU};
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic is_div_op(input logic [MD_OP_LEN-1:0] op);
    return op inside {MD_OP_DIV, MD_OP_DIVU};
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [MD_OP_LEN-1:0] op);
    return op inside {MD_OP_MULT, MD_OP_DIV, MD_OP_MADD, MD_OP_MSUB};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the execute stage (master) and md_unit (slave).
interface md_unit_if #(
  parameter int WIDTH = 32
);
  import md_unit_pkg::*;

  logic                 start;
  logic [MD_OP_LEN-1:0] op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 busy;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_unit_divider.sv
// Restoring divider, one quotient bit per loop iteration, unrolled so the
// result is available at issue. Signed division works on magnitudes and
// fixes the signs afterwards: quotient truncates toward zero, remainder
// follows the dividend. A zero divisor yields don't-care results that the
// caller discards.
module md_unit_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH:0]   rem;

  // Magnitude restoring division followed by sign fix-up.
  always_comb begin
    neg_a = is_signed & dividend[WIDTH-1];
    neg_b = is_signed & divisor[WIDTH-1];
    mag_a = neg_a ? (~dividend + 1'b1) : dividend;
    mag_b = neg_b ? (~divisor + 1'b1) : divisor;
    q_mag = '0;
    rem   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], mag_a[i]};
      if (rem >= {1'b0, mag_b}) begin
        rem      = rem - {1'b0, mag_b};
        q_mag[i] = 1'b1;
      end
    end
    quotient  = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    remainder = neg_a ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed at issue and
// parked in a pending register; a down-counter holds busy for the fixed
// op latency and the pending value commits on the edge ending the last
// busy cycle. Flush or reset while running drops the pending result.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             pend_we_q, pend_we_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;

  logic               op_signed;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;

  md_unit_divider #(.WIDTH(WIDTH)) u_div (
    .dividend  (bus.a),
    .divisor   (bus.b),
    .is_signed (op_signed),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Issue-time multiply and accumulate; extension width makes the
  // truncated 2*WIDTH product correct for both signed and unsigned ops.
  always_comb begin
    op_signed = is_signed_op(bus.op);
    a_ext     = op_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    b_ext     = op_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    product   = a_ext * b_ext;
    acc       = {hi_q, lo_q};
    case (bus.op)
      MD_OP_MADD, MD_OP_MADDU: mul_res = acc + product;
      MD_OP_MSUB, MD_OP_MSUBU: mul_res = acc - product;
      default:                 mul_res = product;
    endcase
  end

  // Next-state, latency counter, HI/LO writes and pending-result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_we_d = pend_we_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.op == MD_OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == MD_OP_MTLO) begin
            lo_d = bus.a;
          end else if (is_mul_op(bus.op)) begin
            state_d                = ST_RUN;
            cnt_d                  = CNT_W'(MUL_CYCLES - 1);
            pend_we_d              = 1'b1;
            {pend_hi_d, pend_lo_d} = mul_res;
          end else if (is_div_op(bus.op)) begin
            state_d   = ST_RUN;
            cnt_d     = CNT_W'(DIV_CYCLES - 1);
            pend_we_d = (bus.b != '0);
            pend_hi_d = div_r;
            pend_lo_d = div_q;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pend_we_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and architectural HI/LO, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  // Pending result data; only meaningful while pend_we_q is set.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
